// File: rtl/fifo_fc_param.sv
// fifo_fc_param: RAM-backed synchronous FIFO with flow control.
// The fill level is kept in a separate occupancy register. The FIFO has
// programmable almost-full/almost-empty thresholds, a hysteretic pause output,
// and sticky overflow/underflow errors.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   data_in, push, pop      write data / write request / read request
//   umbral_almost_full      pause-set threshold (0 disables almost_full/pause)
//   umbral_almost_empty     pause-release threshold
//   err_clear               clears sticky error flags
//   data_out, valid_out     registered read data, 1-cycle valid pulse
//   occupancy               stored entries 0..DEPTH
//   fifo_empty, fifo_full, almost_full, almost_empty   occupancy decodes
//   pause                   registered hysteretic flow-control flag
//   err_overflow, err_underflow, error   sticky error flags
module fifo_fc_param #(
  parameter int AW = 3,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          push,
  input  logic          pop,
  input  logic [AW:0]   umbral_almost_full,
  input  logic [AW:0]   umbral_almost_empty,
  input  logic          err_clear,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic [AW:0]   occupancy,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          pause,
  output logic          err_overflow,
  output logic          err_underflow,
  output logic          error
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok, push_ok;
  logic [AW:0]   occ_next;

  // Acceptance uses only current-cycle registers. When the FIFO is full, a
  // push is still accepted if a pop is accepted in the same cycle, because
  // the pop frees the slot (pass-through).
  assign pop_ok   = pop && (occupancy != '0);
  assign push_ok  = push && ((occupancy != DEPTH_C) || pop_ok);
  assign occ_next = occupancy + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

  assign fifo_empty   = (occupancy == '0);
  assign fifo_full    = (occupancy == DEPTH_C);
  assign almost_full  = (umbral_almost_full != '0) && (occupancy >= umbral_almost_full);
  assign almost_empty = (occupancy <= umbral_almost_empty);
  assign error        = err_overflow | err_underflow;

  // Storage has no reset. Writes are gated during reset, so a push in the
  // reset cycle leaves no trace in memory.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      pause         <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      occupancy <= occ_next;
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      // Pause looks ahead at occ_next so that it rises on the same edge as
      // occupancy. If the thresholds overlap, the set condition wins.
      if ((umbral_almost_full != '0) && (occ_next >= umbral_almost_full))
        pause <= 1'b1;
      else if (occ_next <= umbral_almost_empty)
        pause <= 1'b0;
      // A new error in the same cycle as err_clear beats the clear.
      err_overflow  <= (err_overflow  & ~err_clear) | (push & ~push_ok);
      err_underflow <= (err_underflow & ~err_clear) | (pop  & ~pop_ok);
    end
  end
endmodule

// File: tb/tb_fifo_fc_param.sv
module tb_fifo_fc_param;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          push, pop, err_clear;
  logic [AW:0]   af, ae;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   occupancy;
  logic          fifo_empty, fifo_full, almost_full, almost_empty;
  logic          pause, err_overflow, err_underflow, error;

  int checks = 0;
  int errors = 0;

  fifo_fc_param #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
    .umbral_almost_full(af), .umbral_almost_empty(ae), .err_clear(err_clear),
    .data_out(data_out), .valid_out(valid_out), .occupancy(occupancy),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_full(almost_full),
    .almost_empty(almost_empty), .pause(pause), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .error(error)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; err_clear = 1'b0;
    data_in = '0; af = '0; ae = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_occ", occupancy, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_aempty", almost_empty, 1);
    check("rst_afull", almost_full, 0);
    check("rst_pause", pause, 0);
    check("rst_error", error, 0);
    check("rst_valid", valid_out, 0);
    check("rst_dout", data_out, 0);

    // Fill with 0x11..0x88, then overflow with 0x99
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(8'h11 * (i + 1));
      tick();
      check("fill_occ", occupancy, i + 1);
    end
    check("fill_full", fifo_full, 1);
    check("fill_error", error, 0);
    check("fill_pause_af0", pause, 0);
    data_in = 8'h99;
    tick();
    push = 1'b0;
    check("ovf_flag", err_overflow, 1);
    check("ovf_occ", occupancy, 8);

    // Drain in order, then underflow
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain_valid", valid_out, 1);
      check("drain_data", data_out, 8'h11 * (i + 1));
    end
    check("drain_empty", fifo_empty, 1);
    tick();
    pop = 1'b0;
    check("udf_flag", err_underflow, 1);
    check("udf_valid", valid_out, 0);
    check("udf_dout_hold", data_out, 8'h88);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clr_error", error, 0);
    check("clr_valid", valid_out, 0);

    // Pause hysteresis with AF=6, AE=2
    af = 4'd6; ae = 4'd2;
    push = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'(i);
      tick();
      check("hy_push_pause", pause, (i == 5) ? 1 : 0);
    end
    push = 1'b0;
    check("hy_afull", almost_full, 1);
    pop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hy_pop_data", data_out, i);
      // occupancy after this pop is 5-i; pause releases at 2
      check("hy_pop_pause", pause, ((5 - i) >= 3) ? 1 : 0);
      if (i == 3) check("hy_aempty", almost_empty, 1);
    end
    pop = 1'b0;

    // AF=0 disables pause and almost_full, even when full
    af = 4'd0;
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(8'h11 * (i + 1));
      tick();
      check("af0_pause", pause, 0);
    end
    push = 1'b0;
    check("af0_afull", almost_full, 0);
    check("af0_full", fifo_full, 1);

    // Full pass-through: push+pop for 10 cycles
    push = 1'b1; pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(8'hA0 + i);
      tick();
      check("pt_occ", occupancy, 8);
      check("pt_valid", valid_out, 1);
      check("pt_data", data_out, (i < 8) ? 8'h11 * (i + 1) : 8'hA0 + (i - 8));
    end
    check("pt_error", error, 0);
    push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("pt_drain", data_out, 8'hA2 + i);
    end
    pop = 1'b0;
    check("pt_empty", fifo_empty, 1);

    // Push+pop on empty: push wins, pop rejected
    push = 1'b1; pop = 1'b1; data_in = 8'h5A;
    tick();
    push = 1'b0;
    check("ep_occ", occupancy, 1);
    check("ep_udf", err_underflow, 1);
    check("ep_valid", valid_out, 0);
    tick();
    pop = 1'b0;
    check("ep_valid2", valid_out, 1);
    check("ep_data", data_out, 8'h5A);
    check("ep_occ0", occupancy, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // Reset mid-transfer at occupancy 5 with both errors set
    af = 4'd6; ae = 4'd2;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data_in = 8'(8'h21 + i);
      tick();
    end
    push = 1'b0; pop = 1'b1;
    tick(); tick(); tick();
    pop = 1'b0;
    check("pre_occ", occupancy, 5);
    check("pre_ovf", err_overflow, 1);
    check("pre_udf", err_underflow, 1);
    check("pre_pause", pause, 1);
    check("pre_data", data_out, 8'h23);
    reset = 1'b1; push = 1'b1; data_in = 8'hEE;
    tick();
    reset = 1'b0; push = 1'b0;
    check("mr_occ", occupancy, 0);
    check("mr_empty", fifo_empty, 1);
    check("mr_pause", pause, 0);
    check("mr_error", error, 0);
    check("mr_valid", valid_out, 0);
    push = 1'b1; data_in = 8'h3C;
    tick();
    push = 1'b0; pop = 1'b1;
    tick();
    pop = 1'b0;
    check("mr_rt_valid", valid_out, 1);
    check("mr_rt_data", data_out, 8'h3C);
    check("mr_rt_occ", occupancy, 0);
    check("mr_rt_error", error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_fc_param.md
Name: fifo_fc_param

Overview:
Parametrised synchronous FIFO with built-in flow control. It is the next generation of the team's RAM-backed FIFO and is used between the round-robin arbiter and the downstream state machine.
- Adds an explicit occupancy counter, full/empty flags and programmable almost-full/almost-empty thresholds.
- Provides a hysteretic `pause` output and sticky, separately clearable overflow/underflow errors.
- Guarantees defined behaviour for simultaneous push/pop at every fill level.

Parameters:
AW, 3, address width; DEPTH = 2**AW entries
DW, 6, data width in bits

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  DW  write data, sampled on accepted push
push  in  1  write request
pop  in  1  read request
umbral_almost_full  in  AW+1  almost-full / pause-set threshold; 0 = disabled
umbral_almost_empty  in  AW+1  almost-empty / pause-release threshold
err_clear  in  1  clears sticky error flags
data_out  out  DW  registered read data
valid_out  out  1  data_out valid (1-cycle pulse)
occupancy  out  AW+1  stored entries, 0..DEPTH
fifo_empty  out  1  occupancy==0
fifo_full  out  1  occupancy==DEPTH
almost_full  out  1  umbral_almost_full!=0 && occupancy>=umbral_almost_full
almost_empty  out  1  occupancy<=umbral_almost_empty
pause  out  1  registered hysteretic flow-control flag
err_overflow  out  1  sticky: push rejected
err_underflow  out  1  sticky: pop rejected
error  out  1  err_overflow | err_underflow

Behaviour:
Storage and pointers
- Internal DW x DEPTH array.
- wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
- occupancy is a separate AW+1-bit register; pointers are never compared to derive fill level.

Acceptance rules, evaluated on current-cycle registers
- pop_ok = pop && occupancy!=0.
- push_ok = push && (occupancy!=DEPTH || pop_ok). Full plus simultaneous pop is a legal pass-through.
- occupancy_next = occupancy + push_ok - pop_ok.
- Simultaneous push+pop when empty: push accepted, pop rejected, err_underflow set, occupancy becomes 1.
- Simultaneous push+pop when full: both accepted, occupancy unchanged, no error.

Write and read
- Write: on push_ok, mem[wr_ptr] <= data_in and wr_ptr++. A rejected push writes nothing and leaves wr_ptr unchanged.
- Read: on pop_ok, data_out <= mem[rd_ptr], rd_ptr++, and valid_out=1 on the following cycle. Latency is 1 clock.
- A rejected pop does not pulse valid_out and does not move rd_ptr.
- data_out holds its last value when no pop is accepted.
- A same-cycle push and pop to the same address cannot occur, because pop requires occupancy!=0.

Flags
- fifo_empty, fifo_full, almost_full and almost_empty are combinational decodes of the occupancy register, so they change on the same edge as occupancy.

Pause (registered, computed from occupancy_next and current thresholds)
- If umbral_almost_full!=0 && occupancy_next>=umbral_almost_full, pause <= 1.
- Else if occupancy_next<=umbral_almost_empty, pause <= 0.
- Else pause holds.
- The set condition has priority when the thresholds overlap.
- Threshold changes take effect on the next edge.

Errors
- err_overflow <= 1 when push && !push_ok.
- err_underflow <= 1 when pop && !pop_ok.
- Errors are sticky; err_clear zeroes them next edge.
- A new error in the same cycle as err_clear wins, so the flag stays 1.

Reset (synchronous, any time, including mid-transfer)
- Cleared to 0: wr_ptr, rd_ptr, occupancy, data_out, valid_out, pause, err_overflow, err_underflow.
- Memory contents are not cleared.
- Output values after reset: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0 unless the threshold is 0 (in which case also 0), error=0.
- push/pop in the reset cycle are ignored.

Test Plan:
- AW=3, DW=8: reset, push 0x11..0x88 on 8 consecutive cycles -> occupancy steps 1..8; fifo_full=1 after the 8th; error=0. A 9th push of 0x99 without pop -> err_overflow=1, occupancy=8, contents unchanged.
- From full, pop 8 consecutive cycles -> valid_out high 8 cycles, each 1 cycle after its pop, with data_out 0x11..0x88 in order; fifo_empty=1. A 9th pop -> err_underflow=1, no valid_out; err_clear -> error=0 next cycle.
- Thresholds AF=6, AE=2, from empty: 6 pushes -> pause=1 on the edge occupancy becomes 6. Pops to occupancy 3 -> pause stays 1. Pop to 2 -> pause=0 on that edge. AF=0 -> pause never asserts.
- Full FIFO, push+pop together for 10 cycles with data 0xA0..0xA9 -> occupancy stays 8, no error. Pointers wrap, and popped data is the original 8 entries followed by 0xA0, 0xA1, in order.
- Empty FIFO, push 0x5A + pop together -> occupancy=1, err_underflow=1, no valid_out. The next pop returns 0x5A.
- Occupancy 5 with both errors set, assert reset one cycle while pushing -> next cycle occupancy=0, fifo_empty=1, pause=0, error=0, valid_out=0. A subsequent push/pop round-trips correctly.
